// File: rtl/paddle_control_pkg.sv
// Shared constants and types for the paddle position path.
// Contents: screen geometry (SCREEN_HEIGHT, PADDLE_HEIGHT, Y_MAX, Y_CENTER),
//           position width, paddle direction enum and its decoder.
package pong_pkg;

  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned PADDLE_HEIGHT = 50;
  localparam int unsigned Y_MAX         = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int unsigned Y_CENTER      = Y_MAX / 2;
  localparam int unsigned POS_W         = 10;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  // Both buttons pressed cancels out and never moves the paddle.
  function automatic dir_t decode_dir(input logic up, input logic down);
    dir_t d;
    d = HOLD;
    if (up && !down) d = UP;
    else if (down && !up) d = DOWN;
    return d;
  endfunction

endpackage

// File: rtl/paddle_control_if.sv
// Frame tick, raw player buttons and the paddle positions handed to the renderer.
// Modports: master drives the frame tick and buttons and observes positions;
//           slave (paddle_control) consumes the inputs and drives positions.
interface paddle_control_if;
  import pong_pkg::*;

  logic             i_frame_tick;
  logic             i_p1_up;
  logic             i_p1_down;
  logic             i_p2_up;
  logic             i_p2_down;
  logic [POS_W-1:0] o_y_paddle1_pos;
  logic [POS_W-1:0] o_y_paddle2_pos;

  modport master (
    output i_frame_tick, i_p1_up, i_p1_down, i_p2_up, i_p2_down,
    input  o_y_paddle1_pos, o_y_paddle2_pos
  );

  modport slave (
    input  i_frame_tick, i_p1_up, i_p1_down, i_p2_up, i_p2_down,
    output o_y_paddle1_pos, o_y_paddle2_pos
  );
endinterface

// File: rtl/paddle_axis.sv
// One player's paddle: button synchronisers and debouncers, direction decode,
// optional per-frame step acceleration (PADDLE_ACCEL_EN) and clamped Y position.
// Ports: clk, rst_n (synchronous, active-low), frame_tick, btn_up/btn_down
//        (raw async), pos (registered top-edge Y).
module paddle_axis
  import pong_pkg::*;
#(
  parameter int unsigned debounce_cycles = 250000,
  parameter int unsigned paddle_speed    = 4,
  parameter int unsigned max_speed       = 12,
  parameter int unsigned y_max           = Y_MAX,
  parameter int unsigned y_center        = Y_CENTER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [POS_W-1:0] pos
);

  localparam int unsigned CNT_W    = $clog2(debounce_cycles + 1);
  localparam int unsigned CNT_LAST = debounce_cycles - 1;
  localparam int unsigned ARITH_W  = POS_W + 1;

  if (max_speed < paddle_speed) begin : g_bad_speed
    $error("max_speed must not be below paddle_speed");
  end

  // Index 0 = up button, index 1 = down button.
  logic [1:0]       raw_c;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [CNT_W-1:0] cnt [2];

  assign raw_c = {btn_down, btn_up};

  // Level is accepted only after differing from the debounced value for debounce_cycles clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(CNT_LAST)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  dir_t               dir_c;
  logic [ARITH_W-1:0] step_c;

  assign dir_c = decode_dir(deb[0], deb[1]);

`ifdef PADDLE_ACCEL_EN
  logic [ARITH_W-1:0] step_q;
  dir_t               last_dir_q;

  // A fresh or changed direction restarts from the base step on this very tick.
  always_comb begin
    step_c = ARITH_W'(paddle_speed);
    if (dir_c == last_dir_q) step_c = step_q;
  end

  // Step for the next tick grows by one while the direction persists.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q     <= ARITH_W'(paddle_speed);
      last_dir_q <= HOLD;
    end else if (frame_tick) begin
      last_dir_q <= dir_c;
      if (dir_c == HOLD) step_q <= ARITH_W'(paddle_speed);
      else if (step_c >= ARITH_W'(max_speed)) step_q <= ARITH_W'(max_speed);
      else step_q <= step_c + ARITH_W'(1);
    end
  end
`else
  assign step_c = ARITH_W'(paddle_speed);
`endif

  logic [ARITH_W-1:0] pos_ext_c;
  logic [ARITH_W-1:0] pos_sum_c;
  logic [POS_W-1:0]   pos_next_c;

  // Clamped move, computed one bit wider so pos+step cannot wrap.
  always_comb begin
    pos_ext_c  = {1'b0, pos};
    pos_sum_c  = pos_ext_c + step_c;
    pos_next_c = pos;
    case (dir_c)
      UP:      pos_next_c = (pos_ext_c < step_c) ? '0 : POS_W'(pos_ext_c - step_c);
      DOWN:    pos_next_c = (pos_sum_c > ARITH_W'(y_max)) ? POS_W'(y_max) : POS_W'(pos_sum_c);
      default: pos_next_c = pos;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pos <= POS_W'(y_center);
    else if (frame_tick) pos <= pos_next_c;
  end

endmodule

// File: rtl/paddle_control.sv
// Per-frame paddle position generator for both players, feeding the paddle renderer.
// Positions only change on the edge after i_frame_tick, never mid-frame.
// Ports: i_clk, i_rst_n (synchronous, active-low), bus (paddle_control_if.slave:
//        frame tick, four raw buttons, two registered 10-bit Y positions).
// Build option: define PADDLE_ACCEL_EN for per-player step acceleration.
module paddle_control
  import pong_pkg::*;
#(
  parameter int unsigned paddle_height   = PADDLE_HEIGHT,
  parameter int unsigned screen_height   = SCREEN_HEIGHT,
  parameter int unsigned paddle_speed    = 4,
  parameter int unsigned max_speed       = 12,
  parameter int unsigned debounce_cycles = 250000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  paddle_control_if.slave  bus
);

  localparam int unsigned Y_MAX_P    = screen_height - paddle_height;
  localparam int unsigned Y_CENTER_P = Y_MAX_P / 2;

  paddle_axis #(
    .debounce_cycles (debounce_cycles),
    .paddle_speed    (paddle_speed),
    .max_speed       (max_speed),
    .y_max           (Y_MAX_P),
    .y_center        (Y_CENTER_P)
  ) u_p1 (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .frame_tick (bus.i_frame_tick),
    .btn_up     (bus.i_p1_up),
    .btn_down   (bus.i_p1_down),
    .pos        (bus.o_y_paddle1_pos)
  );

  paddle_axis #(
    .debounce_cycles (debounce_cycles),
    .paddle_speed    (paddle_speed),
    .max_speed       (max_speed),
    .y_max           (Y_MAX_P),
    .y_center        (Y_CENTER_P)
  ) u_p2 (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .frame_tick (bus.i_frame_tick),
    .btn_up     (bus.i_p2_up),
    .btn_down   (bus.i_p2_down),
    .pos        (bus.o_y_paddle2_pos)
  );

endmodule

// File: tb/tb_paddle_control.sv
// Bench for paddle_control: directed scenarios with literal expectations plus
// randomized buttons/ticks/resets checked every cycle against a behavioural model.
module tb_paddle_control;

  localparam int DEB   = 4;
  localparam int SPEED = 4;
  localparam int MAXS  = 12;
  localparam int YMAX  = 430;
  localparam int YCEN  = 215;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  paddle_control_if bus();

  paddle_control #(
    .paddle_height   (50),
    .screen_height   (480),
    .paddle_speed    (SPEED),
    .max_speed       (MAXS),
    .debounce_cycles (DEB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: 0=p1_up 1=p1_down 2=p2_up 3=p2_down
  int m_pos[2]    = '{YCEN, YCEN};
  int m_deb[4]    = '{0, 0, 0, 0};
  int m_stable[4] = '{0, 0, 0, 0};
  int m_hist1[4]  = '{0, 0, 0, 0};
  int m_hist2[4]  = '{0, 0, 0, 0};
  int m_streak[2] = '{0, 0};
  int m_last[2]   = '{0, 0};

  function automatic int dir_of(input int up, input int dn);
    if (up != 0 && dn == 0) return 1;
    if (dn != 0 && up == 0) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int raw[4];
    raw[0] = int'(bus.i_p1_up);
    raw[1] = int'(bus.i_p1_down);
    raw[2] = int'(bus.i_p2_up);
    raw[3] = int'(bus.i_p2_down);
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        m_pos[p] = YCEN; m_streak[p] = 0; m_last[p] = 0;
      end
      for (int b = 0; b < 4; b++) begin
        m_deb[b] = 0; m_stable[b] = 0; m_hist1[b] = 0; m_hist2[b] = 0;
      end
    end else begin
      if (bus.i_frame_tick) begin
        for (int p = 0; p < 2; p++) begin
          int d;
          int step;
          d = dir_of(m_deb[2*p], m_deb[2*p+1]);
`ifdef PADDLE_ACCEL_EN
          if (d != 0 && d == m_last[p]) m_streak[p]++;
          else m_streak[p] = 0;
          m_last[p] = d;
          step = SPEED + m_streak[p];
          if (step > MAXS) step = MAXS;
`else
          step = SPEED;
`endif
          if (d == 1) m_pos[p] = (m_pos[p] - step < 0) ? 0 : m_pos[p] - step;
          else if (d == 2) m_pos[p] = (m_pos[p] + step > YMAX) ? YMAX : m_pos[p] + step;
        end
      end
      // A level two clocks old must disagree with the accepted level DEB times in a row.
      for (int b = 0; b < 4; b++) begin
        if (m_hist2[b] != m_deb[b]) m_stable[b]++;
        else m_stable[b] = 0;
        if (m_stable[b] == DEB) begin
          m_deb[b] = m_hist2[b];
          m_stable[b] = 0;
        end
        m_hist2[b] = m_hist1[b];
        m_hist1[b] = raw[b];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("p1_model", 16'(bus.o_y_paddle1_pos), 16'(m_pos[0]));
    check("p2_model", 16'(bus.o_y_paddle2_pos), 16'(m_pos[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic release_all();
    bus.i_p1_up = 1'b0; bus.i_p1_down = 1'b0;
    bus.i_p2_up = 1'b0; bus.i_p2_down = 1'b0;
  endtask

  task automatic do_reset();
    release_all();
    bus.i_frame_tick = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      repeat (gap - 1) @(negedge clk);
      bus.i_frame_tick = 1'b1;
      @(negedge clk);
      bus.i_frame_tick = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_frame_tick = 1'b0;
    release_all();
    @(negedge clk);

    // Reset and idle frames
    do_reset();
    check("reset_p1", 16'(bus.o_y_paddle1_pos), 16'd215);
    check("reset_p2", 16'(bus.o_y_paddle2_pos), 16'd215);
    run_ticks(3, 100);
    check("idle_p1", 16'(bus.o_y_paddle1_pos), 16'd215);
    check("idle_p2", 16'(bus.o_y_paddle2_pos), 16'd215);

    // P1 moves down
    bus.i_p1_down = 1'b1;
    run_ticks(1, 100);
    check("move_p1_t1", 16'(bus.o_y_paddle1_pos), 16'd219);
    run_ticks(1, 100);
`ifdef PADDLE_ACCEL_EN
    check("move_p1_t2", 16'(bus.o_y_paddle1_pos), 16'd224);
`else
    check("move_p1_t2", 16'(bus.o_y_paddle1_pos), 16'd223);
`endif
    check("move_p2", 16'(bus.o_y_paddle2_pos), 16'd215);

    // Clamp at both screen edges
    do_reset();
    bus.i_p1_down = 1'b1;
    bus.i_p2_up   = 1'b1;
    run_ticks(60, 100);
    check("clamp_p1", 16'(bus.o_y_paddle1_pos), 16'd430);
    check("clamp_p2", 16'(bus.o_y_paddle2_pos), 16'd0);

    // Short glitch rejected
    do_reset();
    bus.i_p1_up = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_p1_up = 1'b0;
    repeat (20) @(negedge clk);
    run_ticks(1, 1);
    check("glitch_p1", 16'(bus.o_y_paddle1_pos), 16'd215);

    // Both P1 buttons held: no move; P2 independent
    do_reset();
    bus.i_p1_up = 1'b1; bus.i_p1_down = 1'b1; bus.i_p2_up = 1'b1;
    run_ticks(5, 100);
    check("conflict_p1", 16'(bus.o_y_paddle1_pos), 16'd215);
`ifdef PADDLE_ACCEL_EN
    check("conflict_p2", 16'(bus.o_y_paddle2_pos), 16'd185);
`else
    check("conflict_p2", 16'(bus.o_y_paddle2_pos), 16'd195);
`endif

`ifdef PADDLE_ACCEL_EN
    // Acceleration and restart after release
    do_reset();
    bus.i_p1_up = 1'b1;
    run_ticks(3, 100);
    check("accel_p1_run", 16'(bus.o_y_paddle1_pos), 16'd200);
    bus.i_p1_up = 1'b0;
    run_ticks(1, 100);
    check("accel_p1_hold", 16'(bus.o_y_paddle1_pos), 16'd200);
    bus.i_p1_up = 1'b1;
    run_ticks(1, 100);
    check("accel_p1_restart", 16'(bus.o_y_paddle1_pos), 16'd196);
`endif

    // Randomized buttons, ticks and occasional resets
    do_reset();
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 11) == 0) bus.i_p1_up   = ~bus.i_p1_up;
      if ($urandom_range(0, 11) == 0) bus.i_p1_down = ~bus.i_p1_down;
      if ($urandom_range(0, 11) == 0) bus.i_p2_up   = ~bus.i_p2_up;
      if ($urandom_range(0, 11) == 0) bus.i_p2_down = ~bus.i_p2_down;
      bus.i_frame_tick = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 2999) != 0);
      @(negedge clk);
    end
    bus.i_frame_tick = 1'b0;
    rst_n = 1'b1;
    release_all();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
